// File: rtl/zeroriscy_multdiv_param_pkg.sv
// Shared types for the parametrised zero-riscy multiply/divide unit.
package zeroriscy_multdiv_param_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_MULT,
    MD_DIV_ABS,
    MD_DIV_COMP,
    MD_DIV_FIX,
    MD_DONE
  } md_fsm_e;

  function automatic logic md_is_mul(input md_op_e op);
    return !op[1];
  endfunction

endpackage

// File: rtl/zeroriscy_mult_kernel.sv
// One iteration of the multiplier: signed partial product of {sign,a} with a
// MULT_KW-bit digit of b, added into the top of the accumulator, then shifted right.
module zeroriscy_mult_kernel
  import zeroriscy_multdiv_param_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MULT_KW = 16
) (
  input  logic signed [2*XLEN:0]  acc_i,
  input  logic signed [XLEN:0]    a_i,
  input  logic signed [MULT_KW:0] digit_i,
  output logic signed [2*XLEN:0]  acc_o
);

  localparam int unsigned PW = XLEN + MULT_KW + 2;
  localparam int unsigned SW = 2 * XLEN + MULT_KW + 2;
  localparam int unsigned AW = 2 * XLEN + 1;

  logic signed [PW-1:0] a_ext, d_ext, prod;
  logic signed [SW-1:0] acc_ext, pp_al, sum;

  always_comb begin
    a_ext   = PW'(a_i);
    d_ext   = PW'(digit_i);
    prod    = a_ext * d_ext;
    acc_ext = SW'(acc_i);
    // Partial product enters at bit XLEN; after all digits the shifts realign it.
    pp_al   = SW'(prod) <<< XLEN;
    sum     = acc_ext + pp_al;
    acc_o   = AW'(sum >>> MULT_KW);
  end

endmodule

// File: rtl/zeroriscy_multdiv_param.sv
// Iterative multiply/divide unit: MULT_KW-bit-per-cycle multiplier and
// restoring radix-2 divider with operand latching, kill and divide-by-zero early-out.
module zeroriscy_multdiv_param
  import zeroriscy_multdiv_param_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MULT_KW     = 16,
  parameter bit          DIV_ZERO_EO = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [1:0]      operator_i,
  input  logic [1:0]      signed_mode_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] multdiv_result_o
);

  localparam int unsigned CW   = $clog2(XLEN);
  localparam int unsigned NDIG = XLEN / MULT_KW;

  md_fsm_e                state_q, state_d;
  md_op_e                 op_q, op_d, op_in;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]        a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]        n_q, n_d, d_q, d_d, r_q, r_d, quo_q, quo_d;
  logic [XLEN-1:0]        fin_q, fin_d, res_q, res_d;
  logic signed [2*XLEN:0] acc_q, acc_d, acc_nxt;
  logic signed [MULT_KW:0] digit;
  logic                   n_bit, rem_ge;
  logic [XLEN:0]          rem_sh;
  logic [XLEN-1:0]        rem_sub, done_val;

  function automatic logic [XLEN-1:0] negate_if(input logic neg, input logic [XLEN-1:0] x);
    return neg ? ('0 - x) : x;
  endfunction

  // Only the most significant digit carries the sign of op_b.
  assign digit = {(cnt_q == '0) ? sb_q : 1'b0, b_q[MULT_KW-1:0]};

  zeroriscy_mult_kernel #(
    .XLEN    (XLEN),
    .MULT_KW (MULT_KW)
  ) u_kernel (
    .acc_i   (acc_q),
    .a_i     ({sa_q, a_q}),
    .digit_i (digit),
    .acc_o   (acc_nxt)
  );

  assign n_bit   = n_q[cnt_q];
  assign rem_sh  = {r_q, n_bit};
  assign rem_ge  = rem_sh >= {1'b0, d_q};
  assign rem_sub = XLEN'(rem_sh - {1'b0, d_q});
  assign op_in   = md_op_e'(operator_i);

  always_comb begin
    case (op_q)
      MD_OP_MULL: done_val = acc_q[XLEN-1:0];
      MD_OP_MULH: done_val = acc_q[2*XLEN-1:XLEN];
      default:    done_val = fin_q;
    endcase
  end

  assign busy_o           = (state_q != MD_IDLE);
  assign valid_o          = (state_q == MD_DONE) && !kill_i;
  assign multdiv_result_o = valid_o ? done_val : res_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    d_d     = d_q;
    r_d     = r_q;
    quo_d   = quo_q;
    fin_d   = fin_q;
    acc_d   = acc_q;
    res_d   = valid_o ? done_val : res_q;

    case (state_q)
      MD_IDLE: begin
        if (start_i && !kill_i) begin
          op_d  = op_in;
          a_d   = op_a_i;
          b_d   = op_b_i;
          sa_d  = signed_mode_i[0] & op_a_i[XLEN-1];
          sb_d  = signed_mode_i[1] & op_b_i[XLEN-1];
          acc_d = '0;
          if (md_is_mul(op_in)) begin
            cnt_d   = CW'(NDIG - 1);
            state_d = MD_MULT;
          end else if (DIV_ZERO_EO && (op_b_i == '0)) begin
            fin_d   = (op_in == MD_OP_DIV) ? '1 : op_a_i;
            state_d = MD_DONE;
          end else begin
            state_d = MD_DIV_ABS;
          end
        end
      end
      MD_MULT: begin
        acc_d = acc_nxt;
        b_d   = b_q >> MULT_KW;
        if (cnt_q == '0) state_d = MD_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      MD_DIV_ABS: begin
        n_d     = negate_if(sa_q, a_q);
        d_d     = negate_if(sb_q, b_q);
        r_d     = '0;
        quo_d   = '0;
        cnt_d   = CW'(XLEN - 1);
        state_d = MD_DIV_COMP;
      end
      MD_DIV_COMP: begin
        if (rem_ge) begin
          r_d          = rem_sub;
          quo_d[cnt_q] = 1'b1;
        end else begin
          r_d = rem_sh[XLEN-1:0];
        end
        if (cnt_q == '0) state_d = MD_DIV_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      MD_DIV_FIX: begin
        // A zero divisor yields an all-ones quotient regardless of signs.
        if (op_q == MD_OP_DIV) fin_d = (d_q == '0) ? '1 : negate_if(sa_q ^ sb_q, quo_q);
        else                   fin_d = negate_if(sa_q, r_q);
        state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase

    if (kill_i && (state_q != MD_IDLE)) state_d = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      op_q    <= MD_OP_MULL;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      quo_q   <= '0;
      fin_q   <= '0;
      res_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      d_q     <= d_d;
      r_q     <= r_d;
      quo_q   <= quo_d;
      fin_q   <= fin_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
    end
  end

endmodule
